// File: rtl/packed_word_unpacker.sv
// Unpacks one NUM_WORDS x WORD_W packed vector into a word stream, word 0 first.
// A new vector can be taken on the last-word handshake, so back-to-back vectors stream without a gap.
module packed_word_unpacker #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 6,
   parameter int IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WORD_W*NUM_WORDS-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WORD_W-1:0]           out_data,
   output logic [IDX_W-1:0]            out_idx,
   output logic                        out_last,
   output logic                        busy
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // the producer holds valid and data until that edge, and ready may depend
   // combinationally on the consumer's ready (in_ready follows out_ready in SEND).

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t                        state, state_next;
   logic [WORD_W*NUM_WORDS-1:0]   hold, hold_next;
   logic [IDX_W-1:0]              idx, idx_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hold  <= '0;
         idx   <= '0;
      end else begin
         state <= state_next;
         hold  <= hold_next;
         idx   <= idx_next;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold;
      idx_next   = idx;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;
      out_data   = '0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && in_ready) begin
               hold_next  = in_data;
               idx_next   = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (idx == LAST_IDX);
            in_ready  = !rst && out_ready && out_last;
            // Word select is a plain mux on the held vector, so it is stable during a stall.
            for (int k = 0; k < NUM_WORDS; k++) begin
               if (idx == IDX_W'(k)) out_data = hold[k*WORD_W +: WORD_W];
            end
            if (out_ready) begin
               if (out_last) begin
                  idx_next = '0;
                  if (in_valid && in_ready) hold_next = in_data;
                  else                      state_next = IDLE;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign out_idx = idx;

endmodule

// File: tb/tb_packed_word_unpacker.sv
// Bench for packed_word_unpacker: directed table, hand-written corner sequences and
// randomized traffic checked against a word-queue model of the stream.
module tb_packed_word_unpacker;

   localparam int W  = 32;
   localparam int N  = 6;
   localparam int IW = $clog2(N);
   localparam int DW = W * N;

   localparam logic [DW-1:0] V1 = {32'h4, 32'h5, 32'h4, 32'h5, 32'h4, 32'h5};
   localparam logic [DW-1:0] V2 = {32'h0F, 32'h0E, 32'h0D, 32'h0C, 32'h0B, 32'h0A};

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   packed_word_unpacker #(.WORD_W(W), .NUM_WORDS(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );

   // ---------------- reference model ----------------
   // Words still owed downstream for the current vector, front = word on the bus.
   logic [W-1:0] exp_q[$];

   logic          e_in_ready, e_out_valid, e_out_last, e_busy;
   logic [W-1:0]  e_out_data;
   logic [IW-1:0] e_out_idx;

   task automatic model_expect();
      int sz = exp_q.size();
      e_out_valid = (sz > 0);
      e_busy      = (sz > 0);
      e_out_data  = (sz > 0) ? exp_q[0] : '0;
      e_out_idx   = (sz > 0) ? IW'(N - sz) : '0;
      e_out_last  = (sz == 1);
      e_in_ready  = !rst && ((sz == 0) || (out_ready && sz == 1));
   endtask

   task automatic model_advance();
      int  sz = exp_q.size();
      logic take_in;
      take_in = in_valid && !rst && ((sz == 0) || (out_ready && sz == 1));
      if (rst) begin
         exp_q.delete();
      end else begin
         if (sz > 0 && out_ready) void'(exp_q.pop_front());
         if (take_in)
            for (int k = 0; k < N; k++) exp_q.push_back(in_data[k*W +: W]);
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_all(input logic x_in_ready, input logic x_out_valid,
                            input logic [W-1:0] x_out_data, input logic [IW-1:0] x_out_idx,
                            input logic x_out_last, input logic x_busy);
      chk("in_ready",  64'(in_ready),  64'(x_in_ready));
      chk("out_valid", 64'(out_valid), 64'(x_out_valid));
      chk("out_data",  64'(out_data),  64'(x_out_data));
      chk("out_idx",   64'(out_idx),   64'(x_out_idx));
      chk("out_last",  64'(out_last),  64'(x_out_last));
      chk("busy",      64'(busy),      64'(x_busy));
   endtask

   // ---------------- driver ----------------
   task automatic apply(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
      @(negedge clk);
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   task automatic step(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
      apply(r, iv, d, ordy);
      model_expect();
      check_all(e_in_ready, e_out_valid, e_out_data, e_out_idx, e_out_last, e_busy);
      model_advance();
   endtask

   function automatic logic [DW-1:0] rand_vec();
      logic [DW-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = $urandom;
      return v;
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic          r, iv, ordy;
      logic [DW-1:0] d;
      logic          x_in_ready, x_out_valid, x_out_last, x_busy;
      logic [W-1:0]  x_out_data;
      logic [IW-1:0] x_out_idx;
   } row_t;

   row_t tab[9];

   function automatic row_t mk(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy,
                               input logic xir, input logic xov, input logic [W-1:0] xd,
                               input logic [IW-1:0] xi, input logic xl, input logic xb);
      row_t t;
      t.r = r; t.iv = iv; t.d = d; t.ordy = ordy;
      t.x_in_ready = xir; t.x_out_valid = xov; t.x_out_data = xd;
      t.x_out_idx = xi; t.x_out_last = xl; t.x_busy = xb;
      return t;
   endfunction

   initial begin
      // reset held, then one vector delivered with out_ready high throughout
      tab[0] = mk(1, 0, '0, 1, 0, 0, 32'h0, 3'd0, 0, 0);
      tab[1] = mk(0, 1, V1, 1, 1, 0, 32'h0, 3'd0, 0, 0);
      tab[2] = mk(0, 0, V1, 1, 0, 1, 32'h5, 3'd0, 0, 1);
      tab[3] = mk(0, 0, V1, 1, 0, 1, 32'h4, 3'd1, 0, 1);
      tab[4] = mk(0, 0, V1, 1, 0, 1, 32'h5, 3'd2, 0, 1);
      tab[5] = mk(0, 0, V1, 1, 0, 1, 32'h4, 3'd3, 0, 1);
      tab[6] = mk(0, 0, V1, 1, 0, 1, 32'h5, 3'd4, 0, 1);
      tab[7] = mk(0, 0, V1, 1, 1, 1, 32'h4, 3'd5, 1, 1);
      tab[8] = mk(0, 0, V1, 1, 1, 0, 32'h0, 3'd0, 0, 0);

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 9; i++) begin
         apply(tab[i].r, tab[i].iv, tab[i].d, tab[i].ordy);
         check_all(tab[i].x_in_ready, tab[i].x_out_valid, tab[i].x_out_data,
                   tab[i].x_out_idx, tab[i].x_out_last, tab[i].x_busy);
         model_advance();
      end

      // backpressure: 3-cycle stall while idx=2
      step(0, 1, V1, 1);
      step(0, 0, V1, 1);
      step(0, 0, V1, 1);
      repeat (3) step(0, 0, V1, 0);
      repeat (4) step(0, 0, V1, 1);
      step(0, 0, V1, 1);

      // back-to-back: in_valid held high across the vector boundary
      step(0, 1, V1, 1);
      repeat (6) step(0, 1, V2, 1);
      repeat (6) step(0, 0, V2, 1);
      step(0, 0, V2, 1);

      // in_valid raised mid-vector at idx=1; must wait for the last-word handshake
      step(0, 1, V1, 1);
      step(0, 0, V1, 1);
      repeat (5) step(0, 1, V2, 1);
      repeat (6) step(0, 0, V2, 1);
      step(0, 0, V2, 1);

      // reset at idx=3 discards the rest of the vector
      step(0, 1, V1, 1);
      repeat (3) step(0, 0, V1, 1);
      step(1, 0, V1, 1);
      apply(0, 0, V1, 1);
      check_all(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      model_advance();
      repeat (3) step(0, 0, V1, 1);

      // idle stability with out_ready toggling and in_data wiggling
      for (int i = 0; i < 20; i++) step(0, 0, rand_vec(), 1'(i % 2));

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 3) != 0),
              rand_vec(), 1'($urandom_range(0, 3) != 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
